// File: rtl/dp_pkg.sv
// Shared types for the bus datapath sequencer: opcodes, sequencer states and opcode width.
package dp_pkg;

   localparam int OPW = 3;

   typedef enum logic [OPW-1:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_LOAD = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH_A = 2'd1,
      S_EXEC    = 2'd2,
      S_WB      = 2'd3
   } state_e;

   // Codes 101..111 run the sequence but must not commit anything.
   function automatic logic op_reserved(input logic [OPW-1:0] op);
      return (op > OP_LOAD);
   endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for bus_dp_seq: ADD, SUB (carry = no-borrow), AND, OR, LOAD (pass B).
module dp_alu
   import dp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [OPW-1:0]   i_op,
   output logic [WIDTH-1:0] o_y,
   output logic             o_c
);

   logic [WIDTH:0] w_add;
   logic [WIDTH:0] w_sub;

   assign w_add = {1'b0, i_a} + {1'b0, i_b};
   // Two's-complement subtract; the carry-out is set exactly when a >= b.
   assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      o_y = '0;
      o_c = 1'b0;
      case (i_op)
         OP_ADD: begin
            o_y = w_add[WIDTH-1:0];
            o_c = w_add[WIDTH];
         end
         OP_SUB: begin
            o_y = w_sub[WIDTH-1:0];
            o_c = w_sub[WIDTH];
         end
         OP_AND:  o_y = i_a & i_b;
         OP_OR:   o_y = i_a | i_b;
         OP_LOAD: o_y = i_b;
         default: begin
            o_y = '0;
            o_c = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/bus_dp_seq.sv
// Bus-based datapath with a fetch/execute/write-back micro-sequencer.
// Optional flag registers are built only when DP_FLAGS_EN is defined.
//
// state     | meaning
// S_IDLE    | ready for a new op; done pulses here after write-back
// S_FETCH_A | bus = reg[src_a], captured into Y
// S_EXEC    | bus = imm or reg[src_b], Z <= ALU(Y, bus)
// S_WB      | bus = Z, commit to reg[dst], result and flags
module bus_dp_seq
   import dp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             i_clock,
   input  logic             i_clear,
   input  logic             i_op_valid,
   output logic             o_op_ready,
   input  logic [OPW-1:0]   i_op_code,
   input  logic             i_op_imm_sel,
   input  logic [AW-1:0]    i_op_src_a,
   input  logic [AW-1:0]    i_op_src_b,
   input  logic [AW-1:0]    i_op_dst,
   input  logic [WIDTH-1:0] i_op_imm,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic             o_flag_c,
   output logic             o_flag_z,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   state_e           r_state;
   state_e           w_next;

   logic [OPW-1:0]   r_ir_op;
   logic             r_ir_imm_sel;
   logic [AW-1:0]    r_ir_src_a;
   logic [AW-1:0]    r_ir_src_b;
   logic [AW-1:0]    r_ir_dst;
   logic [WIDTH-1:0] r_ir_imm;

   logic [WIDTH-1:0] r_regs [NREGS];
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_z;
   logic [WIDTH-1:0] r_result;
   logic             r_done;

   logic [WIDTH-1:0] w_bus;
   logic [WIDTH-1:0] w_alu_y;
   logic             w_alu_c;
   logic             w_accept;
   logic             w_commit;

   assign w_accept = (r_state == S_IDLE) && i_op_valid;
   assign w_commit = (r_state == S_WB) && !op_reserved(r_ir_op);

   always_ff @(posedge i_clock or negedge i_clear) begin
      if (!i_clear) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_next = S_FETCH_A;
         S_FETCH_A: w_next = S_EXEC;
         S_EXEC:    w_next = S_WB;
         S_WB:      w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_clear) begin
      if (!i_clear) begin
         r_ir_op      <= '0;
         r_ir_imm_sel <= 1'b0;
         r_ir_src_a   <= '0;
         r_ir_src_b   <= '0;
         r_ir_dst     <= '0;
         r_ir_imm     <= '0;
      end else if (w_accept) begin
         r_ir_op      <= i_op_code;
         r_ir_imm_sel <= i_op_imm_sel;
         r_ir_src_a   <= i_op_src_a;
         r_ir_src_b   <= i_op_src_b;
         r_ir_dst     <= i_op_dst;
         r_ir_imm     <= i_op_imm;
      end
   end

   // Single shared bus; LOAD always takes the immediate regardless of imm_sel.
   always_comb begin
      w_bus = '0;
      case (r_state)
         S_FETCH_A: w_bus = r_regs[r_ir_src_a];
         S_EXEC:    w_bus = (r_ir_imm_sel || (r_ir_op == OP_LOAD)) ? r_ir_imm
                                                                   : r_regs[r_ir_src_b];
         S_WB:      w_bus = r_z;
         default:   w_bus = '0;
      endcase
   end

   dp_alu #(.WIDTH(WIDTH)) u_alu (
      .i_a  (r_y),
      .i_b  (w_bus),
      .i_op (r_ir_op),
      .o_y  (w_alu_y),
      .o_c  (w_alu_c)
   );

   always_ff @(posedge i_clock or negedge i_clear) begin
      if (!i_clear) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_y      <= '0;
         r_z      <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == S_WB);
         if (r_state == S_FETCH_A) r_y <= w_bus;
         if (r_state == S_EXEC)    r_z <= w_alu_y;
         if (w_commit) begin
            r_regs[r_ir_dst] <= w_bus;
            r_result         <= w_bus;
         end
      end
   end

`ifdef DP_FLAGS_EN
   logic r_zc;
   logic r_flag_c;
   logic r_flag_z;

   always_ff @(posedge i_clock or negedge i_clear) begin
      if (!i_clear) begin
         r_zc     <= 1'b0;
         r_flag_c <= 1'b0;
         r_flag_z <= 1'b0;
      end else begin
         if (r_state == S_EXEC) r_zc <= w_alu_c;
         if (w_commit) begin
            r_flag_c <= r_zc;
            r_flag_z <= (r_z == '0);
         end
      end
   end

   assign o_flag_c = r_flag_c;
   assign o_flag_z = r_flag_z;
`else
   logic w_unused_c;
   assign w_unused_c = w_alu_c;
   assign o_flag_c   = 1'b0;
   assign o_flag_z   = 1'b0;
`endif

   assign o_op_ready = (r_state == S_IDLE);
   assign o_done     = r_done;
   assign o_result   = r_result;
   assign o_rd_data  = r_regs[i_rd_addr];

endmodule

// File: tb/tb_bus_dp_seq.sv
// Self-checking bench for bus_dp_seq (WIDTH=8, NREGS=4); flag expectations follow DP_FLAGS_EN.
module tb_bus_dp_seq;
   import dp_pkg::*;

`ifdef DP_FLAGS_EN
   localparam bit FLAGS_EN = 1'b1;
`else
   localparam bit FLAGS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clear;
   logic       op_valid;
   logic       op_ready;
   logic [2:0] op_code;
   logic       op_imm_sel;
   logic [1:0] op_src_a, op_src_b, op_dst;
   logic [7:0] op_imm;
   logic       done;
   logic [7:0] result;
   logic       flag_c, flag_z;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;

   always #5 clk = ~clk;

   bus_dp_seq #(.WIDTH(8), .NREGS(4)) dut (
      .i_clock      (clk),
      .i_clear      (clear),
      .i_op_valid   (op_valid),
      .o_op_ready   (op_ready),
      .i_op_code    (op_code),
      .i_op_imm_sel (op_imm_sel),
      .i_op_src_a   (op_src_a),
      .i_op_src_b   (op_src_b),
      .i_op_dst     (op_dst),
      .i_op_imm     (op_imm),
      .o_done       (done),
      .o_result     (result),
      .o_flag_c     (flag_c),
      .o_flag_z     (flag_z),
      .i_rd_addr    (rd_addr),
      .o_rd_data    (rd_data)
   );

   typedef struct {
      logic [2:0] op;
      logic       sel;
      logic [1:0] a, b, d;
      logic [7:0] imm;
      logic [7:0] res;
      logic       c, z;
      logic [7:0] rd;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      logic       c, z;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic sel,
                               input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                               input logic [7:0] imm, input logic [7:0] res,
                               input logic c, input logic z, input logic [7:0] rd);
      vec_t v;
      v.op = op; v.sel = sel; v.a = a; v.b = b; v.d = d; v.imm = imm;
      v.res = res; v.c = c; v.z = z; v.rd = rd;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      op_code = v.op; op_imm_sel = v.sel; op_src_a = v.a; op_src_b = v.b;
      op_dst = v.d; op_imm = v.imm;
   endtask

   task automatic scramble();
      op_code = 3'($urandom); op_imm_sel = 1'($urandom); op_src_a = 2'($urandom);
      op_src_b = 2'($urandom); op_dst = 2'($urandom); op_imm = 8'($urandom);
   endtask

   function automatic exp_t to_exp(input vec_t v);
      exp_t e;
      e.res = v.res; e.c = v.c & FLAGS_EN; e.z = v.z & FLAGS_EN;
      return e;
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest pending op.
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("mon_result", result, e.res);
            chk("mon_flag_c", flag_c, e.c);
            chk("mon_flag_z", flag_z, e.z);
         end
      end
   end

   // Issue one op from IDLE, check per-cycle handshake and latency, then readback.
   task automatic run_op(input vec_t v, input string nm);
      int w = 0;
      while (!op_ready && w < 10) begin @(posedge clk); #1; w++; end
      chk({nm, "_ready_wait"}, op_ready, 1);
      drive(v);
      op_valid = 1'b1;
      sb_q.push_back(to_exp(v));
      @(posedge clk); #1;
      op_valid = 1'b0;
      scramble();
      for (int k = 0; k < 3; k++) begin
         chk({nm, "_busy_ready"}, op_ready, 0);
         chk({nm, "_early_done"}, done, 0);
         @(posedge clk); #1;
      end
      chk({nm, "_done"}, done, 1);
      chk({nm, "_ready_after"}, op_ready, 1);
      rd_addr = v.d;
      #1;
      chk({nm, "_rd_data"}, rd_data, v.rd);
      @(posedge clk); #1;
      chk({nm, "_done_1cyc"}, done, 0);
   endtask

   vec_t vecs[13];
   vec_t bb[3];

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear = 1'b0; op_valid = 1'b0; rd_addr = 2'd0;
      scramble();

      vecs[0]  = mk(OP_LOAD, 1'b0, 2'd0, 2'd0, 2'd1, 8'h7F, 8'h7F, 1'b0, 1'b0, 8'h7F);
      vecs[1]  = mk(OP_LOAD, 1'b0, 2'd3, 2'd3, 2'd2, 8'h01, 8'h01, 1'b0, 1'b0, 8'h01);
      vecs[2]  = mk(OP_ADD,  1'b0, 2'd1, 2'd2, 2'd3, 8'hAA, 8'h80, 1'b0, 1'b0, 8'h80);
      vecs[3]  = mk(OP_LOAD, 1'b1, 2'd2, 2'd1, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFF);
      vecs[4]  = mk(OP_ADD,  1'b1, 2'd0, 2'd3, 2'd0, 8'h01, 8'h00, 1'b1, 1'b1, 8'h00);
      vecs[5]  = mk(OP_LOAD, 1'b0, 2'd0, 2'd0, 2'd1, 8'h05, 8'h05, 1'b0, 1'b0, 8'h05);
      vecs[6]  = mk(OP_LOAD, 1'b0, 2'd0, 2'd0, 2'd2, 8'h07, 8'h07, 1'b0, 1'b0, 8'h07);
      vecs[7]  = mk(OP_SUB,  1'b0, 2'd1, 2'd2, 2'd3, 8'h00, 8'hFE, 1'b0, 1'b0, 8'hFE);
      vecs[8]  = mk(OP_SUB,  1'b1, 2'd2, 2'd0, 2'd2, 8'h07, 8'h00, 1'b1, 1'b1, 8'h00);
      vecs[9]  = mk(OP_LOAD, 1'b0, 2'd0, 2'd0, 2'd1, 8'hF0, 8'hF0, 1'b0, 1'b0, 8'hF0);
      vecs[10] = mk(OP_AND,  1'b1, 2'd1, 2'd3, 2'd2, 8'h3C, 8'h30, 1'b0, 1'b0, 8'h30);
      vecs[11] = mk(OP_OR,   1'b1, 2'd1, 2'd2, 2'd3, 8'h3C, 8'hFC, 1'b0, 1'b0, 8'hFC);
      vecs[12] = mk(OP_LOAD, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00);

      bb[0] = mk(OP_LOAD, 1'b0, 2'd0, 2'd0, 2'd0, 8'h11, 8'h11, 1'b0, 1'b0, 8'h11);
      bb[1] = mk(OP_LOAD, 1'b0, 2'd0, 2'd0, 2'd1, 8'h22, 8'h22, 1'b0, 1'b0, 8'h22);
      bb[2] = mk(OP_ADD,  1'b0, 2'd0, 2'd1, 2'd2, 8'h00, 8'h33, 1'b0, 1'b0, 8'h33);

      // Reset state, with a request held while clear is low.
      op_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", op_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_flag_c", flag_c, 0);
      chk("rst_flag_z", flag_z, 0);
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         #1;
         chk("rst_regs", rd_data, 0);
      end
      op_valid = 1'b0;
      clear = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", op_ready, 1);

      // Reset during EXEC of ADD r3 = r1 + 0x55 aborts it.
      drive(mk(OP_ADD, 1'b1, 2'd1, 2'd0, 2'd3, 8'h55, 8'h55, 1'b0, 1'b0, 8'h55));
      op_valid = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0;
      chk("abort_busy", op_ready, 0);
      @(posedge clk); #2;
      clear = 1'b0;
      #1;
      rd_addr = 2'd3;
      #1;
      chk("abort_ready", op_ready, 1);
      chk("abort_result", result, 0);
      chk("abort_done", done, 0);
      chk("abort_r3", rd_data, 0);
      op_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      op_valid = 1'b0;
      clear = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         chk("abort_no_done", done, 0);
      end
      chk("abort_r3_after", rd_data, 0);
      chk("abort_result_after", result, 0);

      for (int i = 0; i < 13; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back: op_valid stays high across three ops.
      begin
         int idx = 0;
         int acc_t[3];
         int w = 0;
         while (!op_ready && w < 10) begin @(posedge clk); #1; w++; end
         drive(bb[0]);
         op_valid = 1'b1;
         for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
            logic acc;
            if (idx > 0) chk("b2b_ready", op_ready, ((cyc - acc_t[idx-1]) >= 4) ? 1 : 0);
            acc = op_ready;
            if (acc) begin
               sb_q.push_back(to_exp(bb[idx]));
               acc_t[idx] = cyc;
            end
            @(posedge clk); #1;
            if (acc) begin
               idx++;
               if (idx < 3) drive(bb[idx]);
               else begin op_valid = 1'b0; scramble(); end
            end
         end
         op_valid = 1'b0;
         chk("b2b_count", idx, 3);
         chk("b2b_gap01", acc_t[1] - acc_t[0], 4);
         chk("b2b_gap12", acc_t[2] - acc_t[1], 4);
         repeat (4) @(posedge clk);
         #1;
         rd_addr = 2'd2;
         #1;
         chk("b2b_r2", rd_data, 8'h33);
      end

      // Reserved opcode: done pulses but nothing commits.
      run_op(mk(3'b101, 1'b1, 2'd0, 2'd0, 2'd1, 8'h99, 8'h33, 1'b0, 1'b0, 8'h22), "rsvd");

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
